psr_unit: RTL and testbench
===========================

# psr_unit

Processor status register stage that sits directly downstream of the ALU controller. It holds the five condition flags C, L, F, Z and N. Each flag updates only when the controller's per-flag write enable for that bit is set. The block also evaluates the 4-bit branch/jump/set condition for Bcond, Jcond and Scond, and keeps a one-deep shadow copy of the flags for exception entry and return.

## Interface
Parameters:
- `FLAG_W`, default 5: flag vector width. Bit order is {C,L,F,Z,N}, bit 4 = C.
- `COND_W`, default 4: condition code width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `wr_valid`  in  1: the ALU result for the current instruction retires this cycle.
- `stall`  in  1: pipeline hold; suppresses every state update.
- `psr_wr_en`  in  5: per-flag write enable {C,L,F,Z,N} from the ALU controller.
- `flags_in`  in  5: flag values computed by the ALU for this instruction.
- `cond`  in  4: condition code, taken from the instruction's cond field or src[3:0].
- `save`  in  1: exception entry; copy the flags to the shadow register.
- `restore`  in  1: exception return; copy the shadow register back to the flags.
- `psr`  out  5: current registered flags.
- `carry`  out  1: equals `psr[4]`; the carry-in used by ADDC/SUBC.
- `cond_true`  out  1: result of evaluating `cond` against the flags.
- `shadow`  out  5: shadow flag copy.
- `shadow_valid`  out  1: high while the unit is in state SAVED.
- `nest_err`  out  1: sticky error for an illegal save or restore.

## Operation
- Write qualifier: `upd = wr_valid & ~stall`.
- Flag update: when `upd` is high and no restore takes effect, `psr[i] <= psr_wr_en[i] ? flags_in[i] : psr[i]` for each bit i.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 HI: L
  - 0101 LS: ~L
  - 0110 GT: N
  - 0111 LE: ~N
  - 1000 FS: F
  - 1001 FC: ~F
  - 1010 LO: ~L & ~Z
  - 1011 HS: L | Z
  - 1100 LT: ~N & ~Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111: never, 0
- The state machine has two states, NORMAL and SAVED. `shadow_valid` = (state == SAVED).
- `save` in NORMAL, with `stall` low:
  - `shadow` takes the pre-update `psr`.
  - State goes to SAVED.
  - A flag write in the same cycle still applies to `psr`.
- `restore` in SAVED, with `stall` low:
  - `psr` takes `shadow`.
  - State goes to NORMAL.
  - Any flag write in the same cycle is dropped; restore wins.
- Error cases, all of which set `nest_err` and leave the state unchanged:
  - `save` in SAVED: `shadow` is not overwritten.
  - `restore` in NORMAL: `psr` is not modified by the restore.
  - `save` and `restore` high together in either state: both are ignored. Normal flag writes still apply.
- `nest_err` clears only on reset.
- `stall` high freezes `psr`, `shadow`, the state and `nest_err`.

## Timing
- Reset values: `psr` = 0, `shadow` = 0, state NORMAL, `shadow_valid` = 0, `nest_err` = 0.
- `cond_true` after reset follows the zero flags, e.g. UC = 1, EQ = 0, NE = 1.
- Flag write latency is one cycle: `psr` shows the new value the cycle after `upd`.
- `cond_true` and `carry` are combinational from the flag source; they have no pipeline register.
- Reset taken mid-sequence (in SAVED, or with a write pending) discards all pending actions. The next cycle shows the reset values.

## Configuration
- `PSR_FWD_EN` defined:
  - `cond_true` and `carry` are evaluated on the bypassed next-flag value, i.e. `psr` with the qualified `flags_in` merged in.
  - A CMP followed by Bcond resolves with zero bubbles.
  - A restore takes precedence in the bypass path as well.
- `PSR_FWD_EN` undefined:
  - `cond_true` and `carry` use the registered `psr` only.
  - Upstream must insert one bubble between a flag-setting instruction and a dependent Bcond, Jcond, Scond or ADDC/SUBC.

## Structure
- The shared package holds:
  - `FLAG_C`..`FLAG_N` bit-index constants.
  - The `cond_e` enum of the 16 codes.
  - A `psr_state_e` typedef for {NORMAL, SAVED}.
  - The ALU controller's opcode constants, so that decode and this unit agree.
- One sub-module, `cond_eval`: purely combinational (flags, cond) to `cond_true`. It is reused by any later branch-predict stage.

## Test plan
- Reset, then CMP-style write `psr_wr_en`=01011 with `flags_in`=11111 → `psr`=01011 the next cycle. `cond` 0000 gives `cond_true`=1; `cond` 1111 gives 0.
- `psr`=00010, then write with `psr_wr_en`=00010 and `flags_in`=00000 while `stall`=1 → `psr` stays 00010. The same write repeated with `stall`=0 → `psr`=00000.
- `save` with `psr`=10101 plus a same-cycle write giving 00011 → `shadow`=10101, `psr`=00011, `shadow_valid`=1. A later `restore` together with a write → `psr`=10101 (write dropped), `shadow_valid`=0.
- `restore` in NORMAL, then `save` twice → `nest_err`=1 after the first illegal request. `psr` is unchanged and `shadow` keeps the first save.
- With `PSR_FWD_EN` and `psr`=0, a write of Z=1 with `cond`=0000 in the same cycle → `cond_true`=1 that cycle. Without the macro, `cond_true`=0 that cycle and 1 the next.
- All 16 `cond` codes swept against all 32 flag vectors; `cond_true` checked against a reference model of the condition table.

Source files
------------

// File: rtl/psr_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psr_unit_pkg
//  Description : Shared definitions for the processor status register stage:
//                flag bit indices, condition-code enum, PSR state typedef and
//                the ALU controller opcode constants used by decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package psr_unit_pkg;

    // Flag vector bit order is {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_HI = 4'b0100,
        COND_LS = 4'b0101,
        COND_GT = 4'b0110,
        COND_LE = 4'b0111,
        COND_FS = 4'b1000,
        COND_FC = 4'b1001,
        COND_LO = 4'b1010,
        COND_HS = 4'b1011,
        COND_LT = 4'b1100,
        COND_GE = 4'b1101,
        COND_UC = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        SAVED  = 1'b1
    } psr_state_e;

    // ALU controller opcodes, kept here so decode and the PSR stage agree
    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_ADDC  = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_SUBC  = 5'h03;
    localparam logic [4:0] OP_CMP   = 5'h04;
    localparam logic [4:0] OP_AND   = 5'h05;
    localparam logic [4:0] OP_OR    = 5'h06;
    localparam logic [4:0] OP_XOR   = 5'h07;
    localparam logic [4:0] OP_SHIFT = 5'h08;
    localparam logic [4:0] OP_BCOND = 5'h10;
    localparam logic [4:0] OP_JCOND = 5'h11;
    localparam logic [4:0] OP_SCOND = 5'h12;

endpackage
`default_nettype wire

// File: rtl/psr_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : psr_if
//  Description : Bus between the ALU controller and the PSR stage.
//                master = controller side (drives requests, reads flags)
//                slave  = psr_unit side
//                Requests : wr_valid, stall, psr_wr_en, flags_in, cond,
//                           save, restore
//                Results  : psr, carry, cond_true, shadow, shadow_valid,
//                           nest_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface psr_if #(
    parameter int FLAG_W = 5,
    parameter int COND_W = 4
);
    logic              wr_valid;
    logic              stall;
    logic [FLAG_W-1:0] psr_wr_en;
    logic [FLAG_W-1:0] flags_in;
    logic [COND_W-1:0] cond;
    logic              save;
    logic              restore;
    logic [FLAG_W-1:0] psr;
    logic              carry;
    logic              cond_true;
    logic [FLAG_W-1:0] shadow;
    logic              shadow_valid;
    logic              nest_err;

    modport master (
        output wr_valid, stall, psr_wr_en, flags_in, cond, save, restore,
        input  psr, carry, cond_true, shadow, shadow_valid, nest_err
    );

    modport slave (
        input  wr_valid, stall, psr_wr_en, flags_in, cond, save, restore,
        output psr, carry, cond_true, shadow, shadow_valid, nest_err
    );
endinterface
`default_nettype wire

// File: rtl/psr_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational evaluation of a 4-bit branch/jump/set
//                condition code against the {C,L,F,Z,N} flags.
//                Ports: flags (in), cond (in), cond_true (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import psr_unit_pkg::*;
#(
    parameter int FLAG_W = 5,
    parameter int COND_W = 4
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              cond_true
);
    cond_e w_code;
    logic  w_c, w_l, w_f, w_z, w_n;

    assign w_code = cond_e'(cond[3:0]);
    assign w_c    = flags[FLAG_C];
    assign w_l    = flags[FLAG_L];
    assign w_f    = flags[FLAG_F];
    assign w_z    = flags[FLAG_Z];
    assign w_n    = flags[FLAG_N];

    always_comb begin
        cond_true = 1'b0;
        case (w_code)
            COND_EQ: cond_true = w_z;
            COND_NE: cond_true = ~w_z;
            COND_CS: cond_true = w_c;
            COND_CC: cond_true = ~w_c;
            COND_HI: cond_true = w_l;
            COND_LS: cond_true = ~w_l;
            COND_GT: cond_true = w_n;
            COND_LE: cond_true = ~w_n;
            COND_FS: cond_true = w_f;
            COND_FC: cond_true = ~w_f;
            COND_LO: cond_true = ~w_l & ~w_z;
            COND_HS: cond_true = w_l | w_z;
            COND_LT: cond_true = ~w_n & ~w_z;
            COND_GE: cond_true = w_n | w_z;
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/psr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : psr_unit
//  Description : Processor status register stage. Holds the C,L,F,Z,N flags
//                with per-flag write enables, evaluates branch conditions and
//                keeps a one-deep shadow copy for exception entry/return.
//                Ports: clk, reset_n (sync, active-low), bus (psr_if.slave)
//                Optional macro PSR_FWD_EN: cond_true/carry see the bypassed
//                next-flag value instead of the registered flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module psr_unit
    import psr_unit_pkg::*;
#(
    parameter int FLAG_W = 5,
    parameter int COND_W = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    psr_if.slave     bus
);
    psr_state_e        r_state;
    psr_state_e        w_state_next;
    logic [FLAG_W-1:0] r_psr;
    logic [FLAG_W-1:0] r_shadow;
    logic              r_nest_err;
    logic [FLAG_W-1:0] w_psr_next;
    logic [FLAG_W-1:0] w_shadow_next;
    logic              w_err_next;
    logic              w_upd;
    logic [FLAG_W-1:0] w_cond_src;

    assign w_upd = bus.wr_valid & ~bus.stall;

    // Next-state logic. A legal restore overrides any same-cycle flag write;
    // every illegal request only raises the sticky error.
    always_comb begin
        w_state_next  = r_state;
        w_shadow_next = r_shadow;
        w_err_next    = r_nest_err;
        w_psr_next    = r_psr;
        if (w_upd) begin
            w_psr_next = (r_psr & ~bus.psr_wr_en) | (bus.flags_in & bus.psr_wr_en);
        end
        if (!bus.stall) begin
            if (bus.save && bus.restore) begin
                w_err_next = 1'b1;
            end else if (bus.save) begin
                if (r_state == NORMAL) begin
                    w_shadow_next = r_psr;
                    w_state_next  = SAVED;
                end else begin
                    w_err_next = 1'b1;
                end
            end else if (bus.restore) begin
                if (r_state == SAVED) begin
                    w_psr_next   = r_shadow;
                    w_state_next = NORMAL;
                end else begin
                    w_err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= NORMAL;
            r_psr      <= '0;
            r_shadow   <= '0;
            r_nest_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_psr      <= w_psr_next;
            r_shadow   <= w_shadow_next;
            r_nest_err <= w_err_next;
        end
    end

`ifdef PSR_FWD_EN
    // Bypass: restore precedence is already folded into w_psr_next
    assign w_cond_src = w_psr_next;
`else
    assign w_cond_src = r_psr;
`endif

    cond_eval #(
        .FLAG_W (FLAG_W),
        .COND_W (COND_W)
    ) u_cond_eval (
        .flags     (w_cond_src),
        .cond      (bus.cond),
        .cond_true (bus.cond_true)
    );

    assign bus.carry        = w_cond_src[FLAG_C];
    assign bus.psr          = r_psr;
    assign bus.shadow       = r_shadow;
    assign bus.shadow_valid = (r_state == SAVED);
    assign bus.nest_err     = r_nest_err;
endmodule
`default_nettype wire

// File: tb/tb_psr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psr_unit
//  Description : Self-checking bench for psr_unit: directed vector table,
//                hand-written multi-cycle sequences, full condition sweep and
//                randomized traffic against a behavioural flag model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psr_unit;
    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    psr_if #(.FLAG_W(5), .COND_W(4)) bus ();

    psr_unit #(.FLAG_W(5), .COND_W(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PSR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Behavioural model state
    logic [4:0] m_psr;
    logic [4:0] m_shadow;
    bit         m_saved;
    bit         m_err;

    typedef struct {
        logic       wv;
        logic       st;
        logic [4:0] en;
        logic [4:0] fin;
        logic       sv;
        logic       rs;
        logic [3:0] cc;
        logic [4:0] e_psr;
        logic [4:0] e_sh;
        logic       e_sv;
        logic       e_err;
        logic       e_ct;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition table: codes come in pairs; the odd member of each pair is
    // the complement of the even one, except pairs 5 and 6 whose base
    // expression is the odd member.
    function automatic logic ref_cond(input logic [4:0] f, input logic [3:0] c);
        logic base;
        int   pair;
        pair = int'(c) / 2;
        case (pair)
            0: base = f[1];
            1: base = f[4];
            2: base = f[3];
            3: base = f[0];
            4: base = f[2];
            5: base = f[3] | f[1];
            6: base = f[0] | f[1];
            default: base = 1'b1;
        endcase
        return base ^ c[0] ^ ((pair == 5) || (pair == 6));
    endfunction

    function automatic logic [4:0] apply_write(input logic [4:0] p);
        logic [4:0] r;
        r = p;
        if (bus.wr_valid && !bus.stall)
            for (int i = 0; i < 5; i++)
                if (bus.psr_wr_en[i]) r[i] = bus.flags_in[i];
        return r;
    endfunction

    // Flags that the condition logic should see this cycle
    function automatic logic [4:0] model_src();
        if (!FWD) return m_psr;
        if (!bus.stall && bus.restore && !bus.save && m_saved) return m_shadow;
        return apply_write(m_psr);
    endfunction

    task automatic model_step();
        logic [4:0] nxt;
        if (!reset_n) begin
            m_psr = 0; m_shadow = 0; m_saved = 0; m_err = 0;
        end else if (!bus.stall) begin
            nxt = apply_write(m_psr);
            if (bus.save && bus.restore) begin
                m_err = 1; m_psr = nxt;
            end else if (bus.restore) begin
                if (m_saved) begin m_psr = m_shadow; m_saved = 0; end
                else begin m_err = 1; m_psr = nxt; end
            end else if (bus.save) begin
                if (!m_saved) begin m_shadow = m_psr; m_saved = 1; end
                else m_err = 1;
                m_psr = nxt;
            end else begin
                m_psr = nxt;
            end
        end
    endtask

    task automatic drive(input logic wv, input logic st, input logic [4:0] en,
                         input logic [4:0] fin, input logic [3:0] cc,
                         input logic sv, input logic rs);
        bus.wr_valid  = wv;
        bus.stall     = st;
        bus.psr_wr_en = en;
        bus.flags_in  = fin;
        bus.cond      = cc;
        bus.save      = sv;
        bus.restore   = rs;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".psr"},          {3'b0, bus.psr},          {3'b0, m_psr});
        chk({tag, ".shadow"},       {3'b0, bus.shadow},       {3'b0, m_shadow});
        chk({tag, ".shadow_valid"}, {7'b0, bus.shadow_valid}, {7'b0, m_saved});
        chk({tag, ".nest_err"},     {7'b0, bus.nest_err},     {7'b0, m_err});
    endtask

    // Called just after a negedge with inputs driven: checks the
    // combinational outputs, clocks once, checks the registers.
    task automatic cycle(input string tag);
        logic [4:0] src;
        #1;
        src = model_src();
        chk({tag, ".cond_true"}, {7'b0, bus.cond_true}, {7'b0, ref_cond(src, bus.cond)});
        chk({tag, ".carry"},     {7'b0, bus.carry},     {7'b0, src[4]});
        model_step();
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 4'he, 0, 0);
        repeat (2) @(negedge clk);
        m_psr = 0; m_shadow = 0; m_saved = 0; m_err = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        //           wv  st  en        fin       sv  rs  cc       e_psr     e_sh      sv  err ct
        tbl[0]  = '{1'b1,1'b0,5'b01011,5'b11111,1'b0,1'b0,4'b0000,5'b01011,5'b00000,1'b0,1'b0,1'b1};
        tbl[1]  = '{1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b0,4'b1111,5'b01011,5'b00000,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,5'b11111,5'b00010,1'b0,1'b0,4'b0001,5'b00010,5'b00000,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,5'b00010,5'b00000,1'b0,1'b0,4'b0000,5'b00010,5'b00000,1'b0,1'b0,1'b1};
        tbl[4]  = '{1'b1,1'b0,5'b00010,5'b00000,1'b0,1'b0,4'b0000,5'b00000,5'b00000,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,5'b11111,5'b10101,1'b0,1'b0,4'b0010,5'b10101,5'b00000,1'b0,1'b0,1'b1};
        tbl[6]  = '{1'b1,1'b0,5'b11111,5'b00011,1'b1,1'b0,4'b0110,5'b00011,5'b10101,1'b1,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,5'b11111,5'b01000,1'b0,1'b1,4'b1000,5'b10101,5'b10101,1'b0,1'b0,1'b1};
        tbl[8]  = '{1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b1,4'b1110,5'b10101,5'b10101,1'b0,1'b1,1'b1};
        tbl[9]  = '{1'b0,1'b0,5'b00000,5'b00000,1'b1,1'b0,4'b0011,5'b10101,5'b10101,1'b1,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b0,5'b11111,5'b00000,1'b0,1'b0,4'b0001,5'b00000,5'b10101,1'b1,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b0,5'b00000,5'b00000,1'b1,1'b0,4'b1011,5'b00000,5'b10101,1'b1,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b0,5'b11111,5'b01010,1'b1,1'b1,4'b1010,5'b01010,5'b10101,1'b1,1'b1,1'b0};
        tbl[13] = '{1'b1,1'b1,5'b11111,5'b00000,1'b0,1'b1,4'b1101,5'b01010,5'b10101,1'b1,1'b1,1'b1};
        tbl[14] = '{1'b0,1'b0,5'b00000,5'b00000,1'b0,1'b1,4'b1100,5'b10101,5'b10101,1'b0,1'b1,1'b0};

        do_reset();
        check_regs("reset");
        drive(0, 0, 0, 0, 4'b1110, 0, 0); #1;
        chk("reset.UC", {7'b0, bus.cond_true}, 8'd1);
        drive(0, 0, 0, 0, 4'b0000, 0, 0); #1;
        chk("reset.EQ", {7'b0, bus.cond_true}, 8'd0);
        drive(0, 0, 0, 0, 4'b0001, 0, 0); #1;
        chk("reset.NE", {7'b0, bus.cond_true}, 8'd1);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].wv, tbl[i].st, tbl[i].en, tbl[i].fin, 4'he, tbl[i].sv, tbl[i].rs);
            cycle($sformatf("tbl%0d", i));
            drive(0, 0, 0, 0, tbl[i].cc, 0, 0);
            #1;
            chk($sformatf("tbl%0d.psr", i),    {3'b0, bus.psr},          {3'b0, tbl[i].e_psr});
            chk($sformatf("tbl%0d.shadow", i), {3'b0, bus.shadow},       {3'b0, tbl[i].e_sh});
            chk($sformatf("tbl%0d.sv", i),     {7'b0, bus.shadow_valid}, {7'b0, tbl[i].e_sv});
            chk($sformatf("tbl%0d.err", i),    {7'b0, bus.nest_err},     {7'b0, tbl[i].e_err});
            chk($sformatf("tbl%0d.ct", i),     {7'b0, bus.cond_true},    {7'b0, tbl[i].e_ct});
            cycle($sformatf("tbl%0d.idle", i));
        end

        // Same-cycle Z write followed by EQ, then carry write followed by carry use
        do_reset();
        drive(1, 0, 5'b00010, 5'b00010, 4'b0000, 0, 0); #1;
        chk("fwd.ct_same", {7'b0, bus.cond_true}, {7'b0, FWD});
        cycle("fwd.z");
        drive(0, 0, 0, 0, 4'b0000, 0, 0); #1;
        chk("fwd.ct_next", {7'b0, bus.cond_true}, 8'd1);
        cycle("fwd.z_idle");
        drive(1, 0, 5'b10000, 5'b10000, 4'b0010, 0, 0); #1;
        chk("fwd.carry_same", {7'b0, bus.carry}, {7'b0, FWD});
        cycle("fwd.c");
        drive(0, 0, 0, 0, 4'b0010, 0, 0); #1;
        chk("fwd.carry_next", {7'b0, bus.carry}, 8'd1);
        cycle("fwd.c_idle");

        // Reset taken in SAVED with a write and restore pending
        drive(0, 0, 0, 0, 4'he, 1, 0);
        cycle("mid.save");
        reset_n = 1'b0;
        drive(1, 0, 5'b11111, 5'b11111, 4'he, 0, 1);
        cycle("mid.reset");
        reset_n = 1'b1;
        chk("mid.psr",    {3'b0, bus.psr},          8'd0);
        chk("mid.shadow", {3'b0, bus.shadow},       8'd0);
        chk("mid.sv",     {7'b0, bus.shadow_valid}, 8'd0);

        // Every condition code against every flag vector
        for (int v = 0; v < 32; v++) begin
            drive(1, 0, 5'b11111, 5'(v), 4'he, 0, 0);
            cycle("sweep.load");
            for (int c = 0; c < 16; c++) begin
                drive(0, 0, 0, 0, 4'(c), 0, 0);
                cycle($sformatf("sweep.v%0d.c%0d", v, c));
            end
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            drive(1'($urandom), ($urandom_range(0, 4) == 0), 5'($urandom), 5'($urandom),
                  4'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
            cycle("rand");
        end
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
